// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: scoreboarded register read with a
// three-state fetch FSM and a registered write-back port.
module operand_fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_rs1,
  input  logic [2:0]  req_rs2,
  input  logic [2:0]  req_rd,
  input  logic        req_wen,
  output logic [2:0]  rf_raddr1,
  output logic [2:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [2:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_sto,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [2:0]  op_rd,
  output logic        op_wen,
  input  logic        wb_valid,
  input  logic [2:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [7:0]  pending,
  output logic        wb_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t     state;
  state_t     nextState;
  logic [2:0] rs1Q;
  logic [2:0] rs2Q;
  logic [2:0] rdQ;
  logic       wenQ;
  logic       reqFire;
  logic       opFire;
  logic       srcFree;
  logic [7:0] setMask;
  logic [7:0] clrMask;

  assign reqFire = req_valid & req_ready;
  assign opFire  = op_valid & op_ready;

  assign srcFree = ~pending[req_rs1]
                 & ~pending[req_rs2]
                 & (~req_wen | ~pending[req_rd]);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (reqFire) nextState = READ;
      READ: nextState = OUT;
      OUT:  if (opFire) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Handshake and read-address outputs decoded from state
  always_comb begin
    req_ready = 1'b0;
    op_valid  = 1'b0;
    rf_raddr1 = 3'd0;
    rf_raddr2 = 3'd0;
    unique case (state)
      IDLE: req_ready = rst & srcFree;
      READ: begin
        rf_raddr1 = rs1Q;
        rf_raddr2 = rs2Q;
      end
      OUT:  op_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture request fields on acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1Q <= 3'd0;
      rs2Q <= 3'd0;
      rdQ  <= 3'd0;
      wenQ <= 1'b0;
    end else if (reqFire) begin
      rs1Q <= req_rs1;
      rs2Q <= req_rs2;
      rdQ  <= req_rd;
      wenQ <= req_wen;
    end
  end

  // Sample register-file data at the end of READ; hold through OUT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a   <= 32'd0;
      op_b   <= 32'd0;
      op_rd  <= 3'd0;
      op_wen <= 1'b0;
    end else if (state == READ) begin
      op_a   <= rf_rdata1;
      op_b   <= rf_rdata2;
      op_rd  <= rdQ;
      op_wen <= wenQ;
    end
  end

  // Register the write-back onto the register-file write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_sto   <= 1'b0;
      rf_waddr <= 3'd0;
      rf_wdata <= 32'd0;
    end else begin
      rf_sto <= wb_valid;
      if (wb_valid) begin
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end
    end
  end

  assign setMask = (opFire & op_wen) ? (8'b1 << op_rd) : 8'd0;
  assign clrMask = rf_sto ? (8'b1 << rf_waddr) : 8'd0;

  // Scoreboard: set on issue to execute, clear on store; set wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 8'd0;
    end else begin
      pending <= (pending & ~clrMask) | setMask;
    end
  end

  // Sticky flag for write-backs that nobody was waiting for
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_err <= 1'b0;
    end else if (wb_valid && !pending[wb_rd]) begin
      wb_err <= 1'b1;
    end
  end

endmodule
